// File: rtl/piso_serializer.sv
// Parallel-in serial-out framer: start bit, data MSB-first, optional parity,
// then a forced idle gap. Its ser_out feeds the downstream siso delay line.
module piso_serializer #(
   parameter int unsigned WIDTH      = 8,
   parameter bit          PARITY_EN  = 1'b1,
   parameter bit          PARITY_ODD = 1'b0,
   parameter int unsigned GAP_CYCLES = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_valid,
   output logic             in_ready,
   output logic             ser_out,
   output logic             ser_active,
   output logic             frame_done
);

   localparam int unsigned   BW       = $clog2(WIDTH);
   localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_PARITY,
      S_GAP
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] shift_q, shift_d;
   logic [BW-1:0]    bit_cnt_q, bit_cnt_d;
   logic             parity_q, parity_d;
   logic             ser_out_q, ser_out_d;
   logic             ser_active_q, ser_active_d;
   logic             frame_done_q, frame_done_d;
   logic             gap_clr;
   logic             gap_inc;
   logic             gap_last;
   logic             accept;

   assign in_ready   = (state_q == S_IDLE);
   assign accept     = in_valid && in_ready;
   assign ser_out    = ser_out_q;
   assign ser_active = ser_active_q;
   assign frame_done = frame_done_q;

   always_comb begin
      state_d      = state_q;
      shift_d      = shift_q;
      bit_cnt_d    = bit_cnt_q;
      parity_d     = parity_q;
      ser_out_d    = 1'b0;
      ser_active_d = 1'b0;
      frame_done_d = 1'b0;
      gap_clr      = 1'b0;
      gap_inc      = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (accept) begin
               shift_d      = in_data;
               parity_d     = (^in_data) ^ PARITY_ODD;
               state_d      = S_START;
               ser_out_d    = 1'b1;
               ser_active_d = 1'b1;
            end
         end
         S_START: begin
            state_d      = S_DATA;
            bit_cnt_d    = '0;
            ser_out_d    = shift_q[WIDTH-1];
            shift_d      = shift_q << 1;
            ser_active_d = 1'b1;
         end
         S_DATA: begin
            if (bit_cnt_q != BIT_LAST) begin
               bit_cnt_d    = bit_cnt_q + BW'(1);
               ser_out_d    = shift_q[WIDTH-1];
               shift_d      = shift_q << 1;
               ser_active_d = 1'b1;
            end else if (PARITY_EN) begin
               state_d      = S_PARITY;
               ser_out_d    = parity_q;
               ser_active_d = 1'b1;
            end else begin
               frame_done_d = 1'b1;
               if (GAP_CYCLES != 0) begin
                  state_d = S_GAP;
                  gap_clr = 1'b1;
               end else begin
                  state_d = S_IDLE;
               end
            end
         end
         S_PARITY: begin
            frame_done_d = 1'b1;
            if (GAP_CYCLES != 0) begin
               state_d = S_GAP;
               gap_clr = 1'b1;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_GAP: begin
            if (gap_last) begin
               state_d = S_IDLE;
            end else begin
               gap_inc = 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= S_IDLE;
         shift_q      <= '0;
         bit_cnt_q    <= '0;
         parity_q     <= 1'b0;
         ser_out_q    <= 1'b0;
         ser_active_q <= 1'b0;
         frame_done_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         shift_q      <= shift_d;
         bit_cnt_q    <= bit_cnt_d;
         parity_q     <= parity_d;
         ser_out_q    <= ser_out_d;
         ser_active_q <= ser_active_d;
         frame_done_q <= frame_done_d;
      end
   end

   // No gap counter exists at all when the gap is zero-length.
   if (GAP_CYCLES != 0) begin : g_gap
      localparam int unsigned   GW       = $clog2(GAP_CYCLES + 1);
      localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES - 1);

      logic [GW-1:0] gap_cnt_q, gap_cnt_d;

      always_comb begin
         gap_cnt_d = gap_cnt_q;
         if (gap_clr) begin
            gap_cnt_d = '0;
         end else if (gap_inc) begin
            gap_cnt_d = gap_cnt_q + GW'(1);
         end
      end

      always_ff @(posedge clk) begin
         if (rst) begin
            gap_cnt_q <= '0;
         end else begin
            gap_cnt_q <= gap_cnt_d;
         end
      end

      assign gap_last = (gap_cnt_q == GAP_LAST);
   end else begin : g_nogap
      assign gap_last = 1'b1;
   end

endmodule

// File: tb/tb_piso_serializer.sv
// Randomized and directed bench for piso_serializer in three configurations,
// checked against a frame-level queue model plus a 4-deep siso line model.
module tb_piso_serializer;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] in_data;
   logic       in_valid;
   logic       ser  [3];
   logic       act  [3];
   logic       done [3];
   logic       rdy  [3];

   always #5 clk = ~clk;

   piso_serializer u0 (
      .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
      .in_ready(rdy[0]), .ser_out(ser[0]), .ser_active(act[0]),
      .frame_done(done[0])
   );

   piso_serializer #(.PARITY_ODD(1'b1), .GAP_CYCLES(0)) u1 (
      .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
      .in_ready(rdy[1]), .ser_out(ser[1]), .ser_active(act[1]),
      .frame_done(done[1])
   );

   piso_serializer #(.PARITY_EN(1'b0), .GAP_CYCLES(0)) u2 (
      .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
      .in_ready(rdy[2]), .ser_out(ser[2]), .ser_active(act[2]),
      .frame_done(done[2])
   );

   typedef struct packed {
      logic s;
      logic a;
      logic d;
      logic r;
   } ent_t;

   ent_t mq [3][$];
   logic log0 [$];
   logic log1 [$];
   logic [3:0] sq  = '0;
   logic [3:0] esq = '0;
   int n_chk  = 0;
   int n_fail = 0;

   function automatic bit pen(int i);
      return i != 2;
   endfunction

   function automatic bit odd(int i);
      return i == 1;
   endfunction

   function automatic int gap(int i);
      return (i == 0) ? 2 : 0;
   endfunction

   function automatic logic m_rdy(int i);
      return mq[i].size() == 0 || mq[i][0].r;
   endfunction

   function automatic ent_t m_cur(int i);
      if (mq[i].size() == 0) return 4'b0001;
      return mq[i][0];
   endfunction

   task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic push_frame(int i, logic [7:0] w);
      logic p;
      p = logic'(($countones(w) % 2) == 1) ^ odd(i);
      mq[i].push_back(4'b1100);
      for (int b = 7; b >= 0; b--) mq[i].push_back({w[b], 1'b1, 2'b00});
      if (pen(i)) mq[i].push_back({p, 1'b1, 2'b00});
      if (gap(i) > 0) begin
         mq[i].push_back(4'b0010);
         for (int g = 1; g < gap(i); g++) mq[i].push_back(4'b0000);
      end else begin
         mq[i].push_back(4'b0011);
      end
   endtask

   task automatic step();
      ent_t e;
      logic acc [3];
      logic es;
      logic s0;
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
         e = m_cur(i);
         chk($sformatf("ser%0d", i), ser[i], e.s);
         chk($sformatf("act%0d", i), act[i], e.a);
         chk($sformatf("done%0d", i), done[i], e.d);
         chk($sformatf("rdy%0d", i), rdy[i], m_rdy(i));
         acc[i] = in_valid && m_rdy(i);
      end
      chk("siso_q", sq[3], esq[3]);
      log0.push_back(ser[0]);
      log1.push_back(ser[1]);
      es = m_cur(0).s;
      s0 = ser[0];
      @(posedge clk);
      if (rst) begin
         for (int i = 0; i < 3; i++) mq[i].delete();
         sq  = '0;
         esq = '0;
      end else begin
         sq  = {sq[2:0], s0};
         esq = {esq[2:0], es};
         for (int i = 0; i < 3; i++) begin
            if (mq[i].size() > 0) void'(mq[i].pop_front());
            if (acc[i]) push_frame(i, in_data);
         end
      end
      #1;
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      in_valid = 1'b0;
      while ((mq[0].size() + mq[1].size() + mq[2].size()) != 0 && n < 40) begin
         step();
         n++;
      end
      if (n >= 40) chk("idle_timeout", 0, 1);
      repeat (5) step();
   endtask

   task automatic send_one(logic [7:0] w);
      in_data  = w;
      in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      log0.delete();
      log1.delete();
   endtask

   function automatic logic [15:0] pack(ref logic q [$], input int n);
      logic [15:0] v;
      v = '0;
      for (int k = 0; k < n; k++) v[n-1-k] = q[k];
      return v;
   endfunction

   initial begin
      rst      = 1'b1;
      in_valid = 1'b0;
      in_data  = '0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      repeat (10) step();

      send_one(8'hA5);
      repeat (10) step();
      chk("a5_seq", pack(log0, 10), 16'b1101001010);
      wait_idle();

      send_one(8'h01);
      repeat (10) step();
      chk("par_even_01", log0[9], 1);
      chk("par_odd_01", log1[9], 0);
      wait_idle();

      in_data  = 8'hFF;
      in_valid = 1'b1;
      step();
      log1.delete();
      in_data = 8'h00;
      repeat (13) step();
      chk("b2b_seq", pack(log1, 12), 16'b111111111101);
      wait_idle();

      send_one(8'hC3);
      repeat (4) step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      step();
      chk("rst_mid_ser", ser[0], 0);
      chk("rst_mid_siso", sq[3], 0);
      send_one(8'h3C);
      repeat (10) step();
      chk("3c_seq", pack(log0, 10), 16'b1001111000);
      wait_idle();

      for (int c = 0; c < 800; c++) begin
         rst      = ($urandom_range(0, 99) == 0);
         in_valid = ($urandom_range(0, 2) != 0);
         in_data  = 8'($urandom);
         step();
      end
      rst = 1'b0;
      wait_idle();

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
